// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains sync_fifo into a registered valid/ready packet stream via a 2-entry skid buffer
module fifo_stream_reader #(
  parameter int WIDTH   = 32,
  parameter int PKT_LEN = 8,
  parameter int CNT_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  logic             i_enable,
  output logic             o_fifo_rden,
  input  logic [WIDTH-1:0] i_fifo_rdata,
  input  logic             i_fifo_empty,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last
);
  logic [1:0]       occ;
  logic [WIDTH-1:0] skid;
  logic [CNT_W-1:0] pkt_idx;
  logic             acc;
  logic             idx_end;
  assign o_fifo_rden = i_rstn & ~i_clr & i_enable & ~i_fifo_empty & (occ != 2'd2);
  assign o_valid     = occ != 2'd0;
  assign acc         = o_valid & i_ready;
  assign idx_end     = pkt_idx == CNT_W'(PKT_LEN - 1);
  assign o_last      = o_valid & idx_end;
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      occ     <= 2'd0;
      pkt_idx <= '0;
      o_data  <= '0;
      skid    <= '0;
    end else if (i_clr) begin
      occ     <= 2'd0;
      pkt_idx <= '0;
    end else begin
      occ <= occ + {1'b0, o_fifo_rden} - {1'b0, acc};
      if (acc) pkt_idx <= idx_end ? '0 : pkt_idx + 1'b1;
      if (acc && occ == 2'd2) o_data <= skid;
      else if (o_fifo_rden && (acc || occ == 2'd0)) o_data <= i_fifo_rdata;
      else if (o_fifo_rden) skid <= i_fifo_rdata;
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: FIFO model plus scoreboard and vector table for fifo_stream_reader
module tb_fifo_stream_reader;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clr = 1'b0;
  logic        en = 1'b1;
  logic        ready = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_rdata = '0;
  logic        rden;
  logic        valid;
  logic        last;
  logic [31:0] data;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int idx = 0;
  int pops = 0;
  int accs = 0;
  typedef struct {
    logic rstn;
    logic clr;
    logic en;
    logic empty;
    logic ready;
    logic rden;
  } vec_t;
  vec_t vecs[6];
  fifo_stream_reader #(.WIDTH(32), .PKT_LEN(8)) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .i_clr(clr),
    .i_enable(en),
    .o_fifo_rden(rden),
    .i_fifo_rdata(fifo_rdata),
    .i_fifo_empty(fifo_empty),
    .o_valid(valid),
    .i_ready(ready),
    .o_data(data),
    .o_last(last)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask
  function automatic void sync_fifo();
    fifo_empty = fifo_q.size() == 0;
    fifo_rdata = fifo_empty ? 32'h0 : fifo_q[0];
  endfunction
  task automatic fill(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) fifo_q.push_back(32'(i));
    sync_fifo();
  endtask
  task automatic cyc();
    logic p;
    logic a;
    logic l;
    logic [31:0] d;
    #1;
    p = rden;
    a = valid & ready;
    d = data;
    l = last;
    @(posedge clk);
    #1;
    if (a && rstn && !clr) begin
      accs++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h expected no word", d);
      end else begin
        chk("data", d, exp_q.pop_front());
        chk("last", {31'b0, l}, {31'b0, idx == 7});
        idx = (idx + 1) % 8;
      end
    end
    if (p && fifo_q.size() != 0) begin
      pops++;
      exp_q.push_back(fifo_q.pop_front());
    end
    if (!rstn || clr) begin
      exp_q.delete();
      idx = 0;
    end
    sync_fifo();
    #1;
  endtask
  task automatic drain(input int bound);
    int n;
    n = 0;
    ready = 1'b1;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < bound) begin
      cyc();
      n++;
    end
    chk("drain_done", 32'(fifo_q.size() + exp_q.size()), 32'd0);
  endtask
  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    fill(32'h10, 32'h1F);
    repeat (3) begin
      cyc();
      chk("rst_rden", {31'b0, rden}, 32'd0);
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_last", {31'b0, last}, 32'd0);
      chk("rst_data", data, 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      rstn = vecs[i].rstn;
      clr = vecs[i].clr;
      en = vecs[i].en;
      fifo_empty = vecs[i].empty;
      ready = vecs[i].ready;
      #1;
      chk("vec_rden", {31'b0, rden}, {31'b0, vecs[i].rden});
      chk("vec_valid", {31'b0, valid}, 32'd0);
    end
    rstn = 1'b0;
    clr = 1'b0;
    en = 1'b1;
    ready = 1'b1;
    sync_fifo();
    rstn = 1'b1;
    pops = 0;
    accs = 0;
    repeat (17) cyc();
    chk("stream_pops", 32'(pops), 32'd16);
    chk("stream_accs", 32'(accs), 32'd16);
    chk("stream_valid_end", {31'b0, valid}, 32'd0);
    fill(32'h10, 32'h1F);
    ready = 1'b0;
    pops = 0;
    accs = 0;
    repeat (5) cyc();
    chk("bp_pops", 32'(pops), 32'd2);
    chk("bp_rden", {31'b0, rden}, 32'd0);
    chk("bp_valid", {31'b0, valid}, 32'd1);
    chk("bp_hold", data, 32'h10);
    ready = 1'b1;
    repeat (16) cyc();
    chk("bp_accs", 32'(accs), 32'd16);
    chk("bp_empty", 32'(exp_q.size() + fifo_q.size()), 32'd0);
    repeat (5) begin
      cyc();
      chk("empty_rden", {31'b0, rden}, 32'd0);
      chk("empty_valid", {31'b0, valid}, 32'd0);
    end
    fifo_q.push_back(32'hAB);
    sync_fifo();
    #1;
    chk("trickle_rden", {31'b0, rden}, 32'd1);
    cyc();
    chk("trickle_valid", {31'b0, valid}, 32'd1);
    chk("trickle_data", data, 32'hAB);
    cyc();
    chk("trickle_done", {31'b0, valid}, 32'd0);
    fill(32'h20, 32'h27);
    ready = 1'b0;
    repeat (3) cyc();
    chk("full_rden", {31'b0, rden}, 32'd0);
    chk("full_valid", {31'b0, valid}, 32'd1);
    ready = 1'b1;
    chk("accept_cycle_rden", {31'b0, rden}, 32'd0);
    cyc();
    ready = 1'b0;
    chk("resume_rden", {31'b0, rden}, 32'd1);
    cyc();
    chk("refull_rden", {31'b0, rden}, 32'd0);
    chk("refull_head", data, 32'h21);
    drain(40);
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    fill(32'h30, 32'h3F);
    ready = 1'b1;
    accs = 0;
    for (int n = 0; n < 20 && accs < 3; n++) cyc();
    chk("clr_pre_accs", 32'(accs), 32'd3);
    ready = 1'b0;
    cyc();
    chk("clr_pre_full", {31'b0, rden}, 32'd0);
    chk("clr_pre_valid", {31'b0, valid}, 32'd1);
    clr = 1'b1;
    #1;
    chk("clr_rden", {31'b0, rden}, 32'd0);
    cyc();
    clr = 1'b0;
    chk("clr_valid", {31'b0, valid}, 32'd0);
    chk("clr_last", {31'b0, last}, 32'd0);
    chk("clr_fifo_kept", 32'(fifo_q.size()), 32'd11);
    drain(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
